// File: rtl/rc5_key_expand_ctrl.sv
// RC5-W/R/B key expansion sequencer: clears and loads L from the key bytes,
// fills S with the magic progression, then runs the 3*max(T,C) mixing loop.
module rc5_key_expand_ctrl #(
    parameter  int W   = 32,
    parameter  int B   = 16,
    parameter  int R   = 12,
    localparam int U   = W / 8,
    localparam int C   = B / U,
    localparam int T   = 2 * (R + 1),
    localparam int N   = 3 * ((T > C) ? T : C),
    localparam int KAW = (B > 1) ? $clog2(B) : 1,
    localparam int LAW = (C > 1) ? $clog2(C) : 1,
    localparam int TAW = (T > 1) ? $clog2(T) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [KAW-1:0] key_address,
    input  logic [7:0]     key_sub_i,
    output logic [LAW-1:0] L_address,
    input  logic [W-1:0]   L_sub_i,
    output logic [W-1:0]   L_wdata,
    output logic           L_we,
    output logic [TAW-1:0] S_address,
    input  logic [W-1:0]   S_rdata,
    output logic [W-1:0]   S_wdata,
    output logic           S_we,
    output logic [2:0]     fsm_state
);

    localparam int LGW = $clog2(W);
    localparam int ULG = $clog2(U);
    localparam int MXC = (T > C) ? T : C;
    localparam int CNW = $clog2(MXC + 1);
    localparam int ITW = $clog2(N + 1);

    localparam logic [W-1:0] P = (W == 16) ? W'(16'hB7E1) :
                                 (W == 32) ? W'(32'hB7E15163) :
                                             W'(64'hB7E151628AED2A6B);
    localparam logic [W-1:0] Q = (W == 16) ? W'(16'h9E37) :
                                 (W == 32) ? W'(32'h9E3779B9) :
                                             W'(64'h9E3779B97F4A7C15);

    localparam logic [KAW-1:0] LAST_BYTE = KAW'(B - 1);
    localparam logic [CNW-1:0] C_LAST    = CNW'(C - 1);
    localparam logic [CNW-1:0] T_LAST    = CNW'(T - 1);
    localparam logic [ITW-1:0] N_LAST    = ITW'(N - 1);
    localparam logic [TAW-1:0] I_LAST    = TAW'(T - 1);
    localparam logic [LAW-1:0] J_LAST    = LAW'(C - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        L_CLEAR = 3'd1,
        L_LOAD  = 3'd2,
        S_INIT  = 3'd3,
        MIX     = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t         state;
    logic [1:0]     ph;
    logic [KAW-1:0] bi;
    logic [CNW-1:0] cnt;
    logic [ITW-1:0] iter;
    logic [TAW-1:0] mi;
    logic [LAW-1:0] mj;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LGW-1:0] amt);
        logic [2*W-1:0] d;
        d = {x, x} << amt;
        return d[2*W-1:W];
    endfunction

    logic [KAW-1:0] bi_dec;
    logic [W-1:0]   l_tmp;
    logic [W-1:0]   a_next;
    logic [W-1:0]   ab_sum;
    logic [W-1:0]   b_next;
    logic [TAW-1:0] mi_next;
    logic [LAW-1:0] mj_next;

    assign bi_dec  = bi - 1'b1;
    assign l_tmp   = rotl(L_sub_i, LGW'(8)) + {{(W-8){1'b0}}, key_sub_i};
    assign a_next  = rotl(S_rdata + a_reg + b_reg, LGW'(3));
    // b_next is consumed in c2, after a_reg already holds the new A.
    assign ab_sum  = a_reg + b_reg;
    assign b_next  = rotl(L_sub_i + ab_sum, ab_sum[LGW-1:0]);
    assign mi_next = (mi == I_LAST) ? '0 : mi + 1'b1;
    assign mj_next = (mj == J_LAST) ? '0 : mj + 1'b1;

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ph          <= '0;
            bi          <= '0;
            cnt         <= '0;
            iter        <= '0;
            mi          <= '0;
            mj          <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            key_address <= '0;
            L_address   <= '0;
            L_wdata     <= '0;
            L_we        <= 1'b0;
            S_address   <= '0;
            S_wdata     <= '0;
            S_we        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= L_CLEAR;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        L_address <= '0;
                        L_wdata   <= '0;
                        L_we      <= 1'b1;
                    end
                end

                L_CLEAR: begin
                    if (cnt == C_LAST) begin
                        state       <= L_LOAD;
                        L_we        <= 1'b0;
                        ph          <= 2'd0;
                        bi          <= LAST_BYTE;
                        key_address <= LAST_BYTE;
                        L_address   <= LAW'(LAST_BYTE >> ULG);
                    end else begin
                        cnt       <= cnt + 1'b1;
                        L_address <= L_address + 1'b1;
                    end
                end

                // Per byte: ADDR, WAIT, OP, WRITE; read data lands during WAIT.
                L_LOAD: begin
                    case (ph)
                        2'd0: ph <= 2'd1;
                        2'd1: ph <= 2'd2;
                        2'd2: begin
                            L_wdata <= l_tmp;
                            L_we    <= 1'b1;
                            ph      <= 2'd3;
                        end
                        default: begin
                            L_we <= 1'b0;
                            ph   <= 2'd0;
                            if (bi == '0) begin
                                state     <= S_INIT;
                                cnt       <= '0;
                                S_address <= '0;
                                S_wdata   <= P;
                                S_we      <= 1'b1;
                            end else begin
                                bi          <= bi_dec;
                                key_address <= bi_dec;
                                L_address   <= LAW'(bi_dec >> ULG);
                            end
                        end
                    endcase
                end

                S_INIT: begin
                    if (cnt == T_LAST) begin
                        state     <= MIX;
                        S_we      <= 1'b0;
                        S_address <= '0;
                        L_address <= '0;
                        a_reg     <= '0;
                        b_reg     <= '0;
                        mi        <= '0;
                        mj        <= '0;
                        iter      <= '0;
                        ph        <= 2'd0;
                    end else begin
                        cnt       <= cnt + 1'b1;
                        S_address <= S_address + 1'b1;
                        S_wdata   <= S_wdata + Q;
                    end
                end

                // c0 also retires the previous iteration's L write, so the
                // L read address for this iteration is presented in c1.
                MIX: begin
                    case (ph)
                        2'd0: begin
                            L_we      <= 1'b0;
                            L_address <= mj;
                            ph        <= 2'd1;
                        end
                        2'd1: begin
                            a_reg   <= a_next;
                            S_wdata <= a_next;
                            S_we    <= 1'b1;
                            ph      <= 2'd2;
                        end
                        default: begin
                            b_reg     <= b_next;
                            L_wdata   <= b_next;
                            L_we      <= 1'b1;
                            S_we      <= 1'b0;
                            mi        <= mi_next;
                            mj        <= mj_next;
                            S_address <= mi_next;
                            ph        <= 2'd0;
                            if (iter == N_LAST) begin
                                state <= DONE;
                            end else begin
                                iter <= iter + 1'b1;
                            end
                        end
                    endcase
                end

                DONE: begin
                    L_we  <= 1'b0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_key_expand_ctrl.sv
// Bench for rc5_key_expand_ctrl: bench-owned memories around two instances
// (RC5-32/12/16 and RC5-16/12/8), results compared with a plain RC5 key schedule.
module tb_rc5_key_expand_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start0;
    logic start1;

    int checks = 0;
    int errors = 0;

    // ---------------- instance 0: W=32, B=16, R=12 ----------------
    logic        busy0, done0, L_we0, S_we0;
    logic [3:0]  key_address0;
    logic [7:0]  key_sub0;
    logic [1:0]  L_address0;
    logic [31:0] L_sub0, L_wdata0, S_rdata0, S_wdata0;
    logic [4:0]  S_address0;
    logic [2:0]  fsm_state0;
    logic [7:0]  key_mem0[16];
    logic [31:0] l_mem0[4];
    logic [31:0] s_mem0[26];

    rc5_key_expand_ctrl #(.W(32), .B(16), .R(12)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .key_address(key_address0), .key_sub_i(key_sub0),
        .L_address(L_address0), .L_sub_i(L_sub0), .L_wdata(L_wdata0), .L_we(L_we0),
        .S_address(S_address0), .S_rdata(S_rdata0), .S_wdata(S_wdata0), .S_we(S_we0),
        .fsm_state(fsm_state0)
    );

    always @(posedge clk) begin
        key_sub0 <= key_mem0[key_address0];
        L_sub0   <= l_mem0[L_address0];
        S_rdata0 <= s_mem0[S_address0];
        if (L_we0) l_mem0[L_address0] <= L_wdata0;
        if (S_we0) s_mem0[S_address0] <= S_wdata0;
    end

    // ---------------- instance 1: W=16, B=8, R=12 ----------------
    logic        busy1, done1, L_we1, S_we1;
    logic [2:0]  key_address1;
    logic [7:0]  key_sub1;
    logic [1:0]  L_address1;
    logic [15:0] L_sub1, L_wdata1, S_rdata1, S_wdata1;
    logic [4:0]  S_address1;
    logic [2:0]  fsm_state1;
    logic [7:0]  key_mem1[8];
    logic [15:0] l_mem1[4];
    logic [15:0] s_mem1[26];

    rc5_key_expand_ctrl #(.W(16), .B(8), .R(12)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .key_address(key_address1), .key_sub_i(key_sub1),
        .L_address(L_address1), .L_sub_i(L_sub1), .L_wdata(L_wdata1), .L_we(L_we1),
        .S_address(S_address1), .S_rdata(S_rdata1), .S_wdata(S_wdata1), .S_we(S_we1),
        .fsm_state(fsm_state1)
    );

    always @(posedge clk) begin
        key_sub1 <= key_mem1[key_address1];
        L_sub1   <= l_mem1[L_address1];
        S_rdata1 <= s_mem1[S_address1];
        if (L_we1) l_mem1[L_address1] <= L_wdata1;
        if (S_we1) s_mem1[S_address1] <= S_wdata1;
    end

    // ---------------- reference key schedule ----------------
    logic [7:0]  key_m[16];
    logic [63:0] exp_s[26];

    function automatic logic [63:0] rotl_m(input logic [63:0] x, input int n, input int w);
        logic [63:0] mask;
        int s;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        x = x & mask;
        s = n % w;
        if (s == 0) return x;
        return ((x << s) | (x >> (w - s))) & mask;
    endfunction

    task automatic model_expand(input int w, input int b);
        logic [63:0] l[16];
        logic [63:0] mask, p, q, a, bb;
        int u, c, t, n, i, j;
        u = w / 8;
        c = b / u;
        t = 26;
        n = 3 * ((t > c) ? t : c);
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        case (w)
            16:      begin p = 64'hB7E1; q = 64'h9E37; end
            32:      begin p = 64'hB7E15163; q = 64'h9E3779B9; end
            default: begin p = 64'hB7E151628AED2A6B; q = 64'h9E3779B97F4A7C15; end
        endcase
        for (int k = 0; k < 16; k++) l[k] = 64'd0;
        for (int k = b - 1; k >= 0; k--)
            l[k / u] = (rotl_m(l[k / u], 8, w) + {56'd0, key_m[k]}) & mask;
        exp_s[0] = p;
        for (int k = 1; k < t; k++) exp_s[k] = (exp_s[k - 1] + q) & mask;
        a = 0; bb = 0; i = 0; j = 0;
        for (int k = 0; k < n; k++) begin
            a = rotl_m(exp_s[i] + a + bb, 3, w);
            exp_s[i] = a;
            bb = rotl_m(l[j] + a + bb, int'((a + bb) & 64'(w - 1)), w);
            l[j] = bb;
            i = (i + 1) % t;
            j = (j + 1) % c;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero0(input string pfx);
        check({pfx, "_busy"}, busy0, 0);
        check({pfx, "_done"}, done0, 0);
        check({pfx, "_key_addr"}, key_address0, 0);
        check({pfx, "_L_addr"}, L_address0, 0);
        check({pfx, "_L_wdata"}, L_wdata0, 0);
        check({pfx, "_L_we"}, L_we0, 0);
        check({pfx, "_S_addr"}, S_address0, 0);
        check({pfx, "_S_wdata"}, S_wdata0, 0);
        check({pfx, "_S_we"}, S_we0, 0);
        check({pfx, "_state_idle"}, fsm_state0, 0);
    endtask

    task automatic load_keys(input bit randomize, input bit ramp);
        for (int k = 0; k < 16; k++) begin
            if (randomize) key_m[k] = 8'($urandom_range(0, 255));
            else if (ramp) key_m[k] = 8'(k);
            else key_m[k] = 8'h00;
            key_mem0[k] = key_m[k];
            if (k < 8) key_mem1[k] = key_m[k];
        end
    endtask

    // One expansion on instance 0. Observations are taken at negedges; cyc
    // counts posedges since the one that sampled start.
    task automatic run0(input string tag, input int restart_at, input int rst_at, input bit mid_checks);
        int cyc, busy_cnt, done_cnt, done_cyc, lw_cnt, both_hi;
        bit aborted;
        busy_cnt = 0; done_cnt = 0; done_cyc = -1; lw_cnt = 0; both_hi = 0; aborted = 0;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        cyc = 0;
        while (cyc <= 400 && !aborted) begin
            start0 = 1'b0;
            busy_cnt += int'(busy0);
            if (done0) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc < 4 + 64) lw_cnt += int'(L_we0);
            if (L_we0 && S_we0) both_hi++;
            if (mid_checks && cyc == 4 + 64) begin
                check({tag, "_L_write_count"}, 64'(lw_cnt), 64'(4 + 16));
                check({tag, "_L0"}, l_mem0[0], 32'h03020100);
                check({tag, "_L3"}, l_mem0[3], 32'h0F0E0D0C);
            end
            if (mid_checks && cyc == 4 + 64 + 26) begin
                check({tag, "_S0_init"}, s_mem0[0], 32'hB7E15163);
                check({tag, "_S1_init"}, s_mem0[1], 32'h5618CB1C);
                check({tag, "_S25_init"}, s_mem0[25], 32'(64'hB7E15163 + 64'd25 * 64'h9E3779B9));
            end
            if (cyc == restart_at) start0 = 1'b1;
            if (cyc == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check_zero0({tag, "_midrst"});
                rst = 1'b0;
                aborted = 1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!aborted) begin
            check({tag, "_done_cycle"}, 64'(done_cyc), 64'd329);
            check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd329);
            check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
            check({tag, "_we_overlap"}, 64'(both_hi), 64'd0);
            for (int k = 0; k < 26; k++)
                check($sformatf("%s_S[%0d]", tag, k), s_mem0[k], exp_s[k]);
        end
    endtask

    task automatic run1(input string tag);
        int cyc, busy_cnt, done_cnt, done_cyc;
        busy_cnt = 0; done_cnt = 0; done_cyc = -1;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        for (cyc = 0; cyc <= 400; cyc++) begin
            busy_cnt += int'(busy1);
            if (done1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            @(negedge clk);
        end
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'd297);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd297);
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        for (int k = 0; k < 26; k++)
            check($sformatf("%s_S[%0d]", tag, k), s_mem1[k], exp_s[k]);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        load_keys(0, 0);
        repeat (3) @(negedge clk);
        check_zero0("reset0");
        check("reset1_busy", busy1, 0);
        check("reset1_state_idle", fsm_state1, 0);
        check("reset1_L_we", L_we1, 0);
        rst = 1'b0;
        @(negedge clk);

        // Ramp key with intermediate L/S checks and a start issued mid-run.
        load_keys(0, 1);
        model_expand(32, 16);
        run0("ramp", 100, -1, 1);

        // All-zero key.
        load_keys(0, 0);
        model_expand(32, 16);
        run0("zero", -1, -1, 0);

        // Reset during MIX, then a fresh expansion with a random key.
        load_keys(1, 0);
        run0("abort", -1, 200, 0);
        @(negedge clk);
        load_keys(1, 0);
        model_expand(32, 16);
        run0("after_rst", -1, -1, 0);

        // Narrow variant.
        load_keys(1, 0);
        model_expand(16, 8);
        run1("w16");

        // One more random key on the default instance.
        load_keys(1, 0);
        model_expand(32, 16);
        run0("rand", 37, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
